// File: rtl/range_stream_driver.sv
// Buffers up to DEPTH samples and replays them as one go/finish framed burst.
// Optional RANGE_CHECK_EN macro adds a running max/min self-check of range_in.
module range_stream_driver #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             start,
  input  logic             clear,
  output logic [CW-1:0]    count,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] data_out,
  output logic             go,
  output logic             finish,
  input  logic [WIDTH-1:0] range_in,
  output logic [WIDTH-1:0] exp_range,
  output logic             mismatch
);

  typedef enum logic [2:0] {IDLE, FIRST, MID, LAST, GAP} state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             go_q, go_d;
  logic             finish_q, finish_d;
  logic             done_q, done_d;
  logic             busy_q;
  logic [AW-1:0]    last_idx;
  logic             load_accept;
  logic             do_clear;

  logic [WIDTH-1:0] mem [DEPTH];

  assign load_ready  = (state_q == IDLE) && (count_q < CW'(DEPTH)) && !start && !clear;
  assign load_accept = load_valid && load_ready;
  assign do_clear    = (state_q == IDLE) && clear;
  assign last_idx    = AW'(count_q - CW'(1));

  // NOTE: the sample store carries no reset; count alone defines which entries are valid.
  always_ff @(posedge clock) begin
    if (load_accept) mem[count_q[AW-1:0]] <= load_data;
  end

  // The d-side values are what the registered outputs will show once the state advances.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    state_d  = state_q;
    idx_d    = idx_q;
    count_d  = count_q;
    data_d   = data_q;
    go_d     = 1'b0;
    finish_d = 1'b0;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (do_clear) begin
          count_d = '0;
        end else if (start && (count_q != '0)) begin
          state_d = FIRST;
          go_d    = 1'b1;
          data_d  = mem[0];
          idx_d   = AW'(1);
        end else if (load_accept) begin
          count_d = count_q + CW'(1);
        end
      end
      FIRST: begin
        if (count_q <= CW'(2)) begin
          state_d  = LAST;
          finish_d = 1'b1;
          data_d   = mem[last_idx];
        end else begin
          state_d = MID;
          data_d  = mem[1];
          idx_d   = AW'(2);
        end
      end
      MID: begin
        data_d = mem[idx_q];
        idx_d  = idx_q + AW'(1);
        if (idx_q == last_idx) begin
          state_d  = LAST;
          finish_d = 1'b1;
        end
      end
      LAST: begin
        state_d = GAP;
        done_d  = 1'b1;
        data_d  = '0;
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        data_d  = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      count_q  <= '0;
      data_q   <= '0;
      go_q     <= 1'b0;
      finish_q <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      count_q  <= count_d;
      data_q   <= data_d;
      go_q     <= go_d;
      finish_q <= finish_d;
      done_q   <= done_d;
      busy_q   <= (state_d != IDLE);
    end
  end

  assign count    = count_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign data_out = data_q;
  assign go       = go_q;
  assign finish   = finish_q;

`ifdef RANGE_CHECK_EN
  logic [WIDTH-1:0] max_q, min_q, exp_q;
  logic [WIDTH-1:0] max_d, min_d;
  logic             mismatch_q;

  // The first sample after an empty buffer seeds both extremes.
  always_comb begin
    max_d = load_data;
    min_d = load_data;
    if (count_q != '0) begin
      if (max_q > load_data) max_d = max_q;
      if (min_q < load_data) min_d = min_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      max_q      <= '0;
      min_q      <= '0;
      exp_q      <= '0;
      mismatch_q <= 1'b0;
    end else if (do_clear) begin
      max_q      <= '0;
      min_q      <= '0;
      exp_q      <= '0;
      mismatch_q <= 1'b0;
    end else begin
      if (load_accept) begin
        max_q <= max_d;
        min_q <= min_d;
        exp_q <= max_d - min_d;
      end
      if ((state_q == IDLE) && (state_d == FIRST)) begin
        mismatch_q <= 1'b0;
      end else if (state_q == GAP) begin
        mismatch_q <= (range_in != exp_q);
      end
    end
  end

  assign exp_range = exp_q;
  assign mismatch  = mismatch_q;
`else
  logic unused_range_in;
  assign unused_range_in = ^range_in;
  assign exp_range       = '0;
  assign mismatch        = 1'b0;
`endif

endmodule

// File: tb/tb_range_stream_driver.sv
// Self-checking bench for range_stream_driver: directed framing cases plus
// randomized buffers compared against a queue-based frame model.
module tb_range_stream_driver;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH + 1);
`ifdef RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic             clock = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] load_data;
  logic             load_valid;
  logic             load_ready;
  logic             start;
  logic             clear;
  logic [CW-1:0]    count;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] data_out;
  logic             go;
  logic             finish;
  logic [WIDTH-1:0] range_in;
  logic [WIDTH-1:0] exp_range;
  logic             mismatch;

  int tests = 0;
  int fails = 0;

  logic [WIDTH-1:0] q [$];
  bit               mm_model = 1'b0;

  always #5 clock = ~clock;

  range_stream_driver #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock      (clock),
    .reset      (reset),
    .load_data  (load_data),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .start      (start),
    .clear      (clear),
    .count      (count),
    .busy       (busy),
    .done       (done),
    .data_out   (data_out),
    .go         (go),
    .finish     (finish),
    .range_in   (range_in),
    .exp_range  (exp_range),
    .mismatch   (mismatch)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [WIDTH-1:0] model_range();
    logic [WIDTH-1:0] mx, mn;
    if (q.size() == 0) return '0;
    mx = q[0];
    mn = q[0];
    foreach (q[i]) begin
      if (q[i] > mx) mx = q[i];
      if (q[i] < mn) mn = q[i];
    end
    return mx - mn;
  endfunction

  function automatic logic [WIDTH-1:0] exp_range_model();
    return RC ? model_range() : '0;
  endfunction

  task automatic load_sample(input logic [WIDTH-1:0] v);
    load_data  = v;
    load_valid = 1'b1;
    @(posedge clock); #1;
    load_valid = 1'b0;
    if (q.size() < DEPTH) q.push_back(v);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    #1;
    check("ready_during_clear", load_ready, 0);
    @(posedge clock); #1;
    clear = 1'b0;
    q.delete();
    mm_model = 1'b0;
    check("count_after_clear", count, 0);
    check("exp_range_after_clear", exp_range, 0);
    check("mismatch_after_clear", mismatch, 0);
  endtask

  // Expected frame: go on the first beat, finish on the last; a single sample is sent twice.
  task automatic run_frame(input bit noise, input logic [WIDTH-1:0] rin);
    int n;
    int len;
    n   = q.size();
    len = (n < 2) ? 2 : n;
    range_in = rin;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    mm_model = 1'b0;
    check("mismatch_at_start", mismatch, mm_model);
    for (int k = 0; k < len; k++) begin
      check("go", go, (k == 0));
      check("finish", finish, (k == len - 1));
      check("data_out", data_out, (n == 1) ? q[0] : q[k]);
      check("busy_in_frame", busy, 1);
      check("done_in_frame", done, 0);
      if (noise) begin
        load_valid = 1'($urandom);
        start      = 1'($urandom);
        clear      = 1'($urandom);
        load_data  = WIDTH'($urandom);
      end
      @(posedge clock); #1;
    end
    load_valid = 1'b0;
    start      = 1'b0;
    clear      = 1'b0;
    check("done_pulse", done, 1);
    check("gap_go", go, 0);
    check("gap_finish", finish, 0);
    check("gap_data", data_out, 0);
    check("gap_busy", busy, 1);
    check("count_kept", count, n);
    @(posedge clock); #1;
    mm_model = RC && (rin != model_range());
    check("done_cleared", done, 0);
    check("busy_cleared", busy, 0);
    check("mismatch_after_done", mismatch, mm_model);
  endtask

  initial begin
    reset      = 1'b1;
    load_data  = '0;
    load_valid = 1'b0;
    start      = 1'b0;
    clear      = 1'b0;
    range_in   = '0;
    #3;
    check("rst_go", go, 0);
    check("rst_finish", finish, 0);
    check("rst_data", data_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_count", count, 0);
    check("rst_exp_range", exp_range, 0);
    check("rst_mismatch", mismatch, 0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    #1;
    check("ready_after_reset", load_ready, 1);

    // Four-sample frame, then a replay with noise on every control input.
    load_sample(8'd5);
    load_sample(8'd9);
    load_sample(8'd2);
    load_sample(8'd7);
    check("count_4", count, 4);
    check("exp_range_4", exp_range, exp_range_model());
    run_frame(1'b0, 8'd7);
    run_frame(1'b1, 8'd7);

    // Empty buffer: start is ignored.
    do_clear();
    start = 1'b1;
    #1;
    check("ready_while_start", load_ready, 0);
    repeat (3) begin
      @(posedge clock); #1;
      check("empty_start_busy", busy, 0);
      check("empty_start_go", go, 0);
      check("empty_start_done", done, 0);
    end
    start = 1'b0;

    // Single sample frame.
    load_sample(8'd42);
    run_frame(1'b0, 8'd0);

    // Full buffer: the extra load is dropped.
    do_clear();
    for (int i = 0; i < DEPTH; i++) load_sample(WIDTH'($urandom));
    check("count_full", count, DEPTH);
    check("ready_full", load_ready, 0);
    load_sample(8'hAA);
    check("count_after_overflow", count, DEPTH);
    run_frame(1'b0, model_range());

    // Specific range-check case, matching and forced-wrong range_in.
    do_clear();
    load_sample(8'd10);
    load_sample(8'd3);
    load_sample(8'd200);
    check("exp_range_197", exp_range, RC ? 197 : 0);
    run_frame(1'b0, 8'd197);
    run_frame(1'b0, 8'd5);
    repeat (2) @(posedge clock);
    #1;
    check("mismatch_holds", mismatch, mm_model);
    do_clear();

    // Randomized buffers with idle gaps between loads.
    for (int it = 0; it < 6; it++) begin
      int n;
      logic [WIDTH-1:0] rin;
      do_clear();
      n = $urandom_range(1, DEPTH);
      for (int i = 0; i < n; i++) begin
        repeat ($urandom_range(0, 2)) @(posedge clock);
        #1;
        load_sample(WIDTH'($urandom));
      end
      check("rand_count", count, n);
      check("rand_exp_range", exp_range, exp_range_model());
      rin = ($urandom_range(0, 2) == 0) ? WIDTH'($urandom) : model_range();
      run_frame(1'($urandom), rin);
    end

    // Reset asserted during MID.
    do_clear();
    for (int i = 0; i < 5; i++) load_sample(WIDTH'(i * 11 + 3));
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    check("pre_reset_go", go, 1);
    @(posedge clock); #1;
    check("pre_reset_mid_data", data_out, q[1]);
    #2 reset = 1'b1;
    #1;
    check("mid_reset_go", go, 0);
    check("mid_reset_finish", finish, 0);
    check("mid_reset_data", data_out, 0);
    check("mid_reset_busy", busy, 0);
    check("mid_reset_count", count, 0);
    check("mid_reset_done", done, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    q.delete();
    mm_model = 1'b0;
    repeat (4) begin
      @(posedge clock); #1;
      check("post_reset_done", done, 0);
      check("post_reset_busy", busy, 0);
      check("post_reset_count", count, 0);
      check("post_reset_ready", load_ready, 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
